dram_port_arbiter: RTL and testbench

Parametrised N-port arbiter that lets several requesters share one DRAM request channel. Typical requesters are the core's load/store path, an instruction fetch unit and a UART loader. It sits between those requesters and the DRAM controller top, using the same valid/rw/addr/din → ready/dout handshake on both sides. It adds selectable round-robin or fixed-priority arbitration and a sticky response-timeout watchdog.

---
 rtl/dram_if_pkg.sv | 21 ++
 rtl/dram_port_arbiter_if.sv | 31 +++
 rtl/dram_port_arbiter_pick.sv | 38 +++
 rtl/dram_port_arbiter.sv | 95 +++++++++
 tb/tb_dram_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dram_if_pkg.sv
// rtl/dram_if_pkg.sv - shared widths, state encoding and arbitration modes for the DRAM port arbiter
package dram_if_pkg;

  localparam int DRAM_ADDR_W = 27;
  localparam int DRAM_DATA_W = 32;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  // Grant index width; a single port still needs one bit to carry index 0.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// rtl/dram_port_arbiter_if.sv - requester-side and DRAM-side handshake bundles
interface dram_req_if import dram_if_pkg::*; #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = DRAM_ADDR_W,
  parameter int DATA_W  = DRAM_DATA_W
);
  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS-1:0]        req_rw;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_din;
  logic [N_PORTS-1:0]        req_ready;
  logic [DATA_W-1:0]         req_dout;

  modport master (output req_valid, req_rw, req_addr, req_din, input req_ready, req_dout);
  modport slave  (input req_valid, req_rw, req_addr, req_din, output req_ready, req_dout);
endinterface

interface dram_chan_if import dram_if_pkg::*; #(
  parameter int ADDR_W = DRAM_ADDR_W,
  parameter int DATA_W = DRAM_DATA_W
);
  logic [ADDR_W-1:0] addr_dram;
  logic [DATA_W-1:0] din_dram;
  logic              rw_dram;
  logic              valid_dram;
  logic [DATA_W-1:0] dout_dram;
  logic              ready_dram;

  modport master (output addr_dram, din_dram, rw_dram, valid_dram, input dout_dram, ready_dram);
  modport slave  (input addr_dram, din_dram, rw_dram, valid_dram, output dout_dram, ready_dram);
endinterface

// File: rtl/dram_port_arbiter_pick.sv
// rtl/dram_port_arbiter_pick.sv - combinational winner selection, round-robin or fixed priority
module dram_arb_pick import dram_if_pkg::*; #(
  parameter  int N_PORTS   = 2,
  parameter  int PRIO_MODE = PRIO_RR,
  localparam int GID_W     = id_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] valid,
  input  logic [GID_W-1:0]   rr_last,
  output logic [GID_W-1:0]   grant,
  output logic               any_valid
);

  logic [GID_W-1:0]     rr_grant;
  logic [GID_W-1:0]     fp_grant;
  logic [2*N_PORTS-1:0] dbl;
  logic [N_PORTS-1:0]   rot;
  int                   start;

  always_comb begin
    fp_grant = '0;
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (valid[i]) fp_grant = GID_W'(i);
  end

  // Rotate so the port after rr_last sits at bit 0, then take the lowest set bit.
  always_comb begin
    start    = (int'(rr_last) + 1) % N_PORTS;
    dbl      = {valid, valid} >> start;
    rot      = dbl[N_PORTS-1:0];
    rr_grant = '0;
    for (int j = N_PORTS - 1; j >= 0; j--)
      if (rot[j]) rr_grant = GID_W'((start + j) % N_PORTS);
  end

  assign grant     = (PRIO_MODE == PRIO_FIXED) ? fp_grant : rr_grant;
  assign any_valid = |valid;

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - N-port DRAM request arbiter with registered outputs and response watchdog
module dram_port_arbiter import dram_if_pkg::*; #(
  parameter  int N_PORTS     = 2,
  parameter  int ADDR_W      = DRAM_ADDR_W,
  parameter  int DATA_W      = DRAM_DATA_W,
  parameter  int PRIO_MODE   = PRIO_RR,
  parameter  int TIMEOUT_CYC = 0,
  localparam int GID_W       = id_width(N_PORTS)
) (
  input  logic             clk,
  input  logic             rstn,
  dram_req_if.slave        req,
  dram_chan_if.master      dram,
  output logic [GID_W-1:0] grant_id,
  output logic             busy,
  output logic             err_timeout
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  arb_state_t       state;
  arb_state_t       next_state;
  logic [GID_W-1:0] rr_last;
  logic [GID_W-1:0] pick;
  logic             any_valid;
  logic [TW-1:0]    tmo_cnt;

  dram_arb_pick #(.N_PORTS(N_PORTS), .PRIO_MODE(PRIO_MODE)) u_pick (
    .valid     (req.req_valid),
    .rr_last   (rr_last),
    .grant     (pick),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (any_valid) next_state = ST_ISSUE;
      ST_ISSUE: if (dram.ready_dram) next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dram.valid_dram <= 1'b0;
      dram.addr_dram  <= '0;
      dram.din_dram   <= '0;
      dram.rw_dram    <= 1'b0;
      req.req_ready   <= '0;
      req.req_dout    <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      err_timeout     <= 1'b0;
      rr_last         <= GID_W'(N_PORTS - 1);
      tmo_cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_valid) begin
          dram.valid_dram <= 1'b1;
          dram.addr_dram  <= req.req_addr[int'(pick)*ADDR_W +: ADDR_W];
          dram.din_dram   <= req.req_din[int'(pick)*DATA_W +: DATA_W];
          dram.rw_dram    <= req.req_rw[pick];
          grant_id        <= pick;
          rr_last         <= pick;
          busy            <= 1'b1;
          tmo_cnt         <= '0;
        end
        ST_ISSUE: begin
          if (dram.ready_dram) begin
            dram.valid_dram <= 1'b0;
            req.req_dout    <= dram.dout_dram;
            req.req_ready   <= N_PORTS'(1) << grant_id;
          // Watchdog only flags; the transaction keeps waiting for the controller.
          end else if (TIMEOUT_CYC > 0 && tmo_cnt < TW'(TIMEOUT_CYC)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) err_timeout <= 1'b1;
          end
        end
        ST_RESP: begin
          req.req_ready <= '0;
          busy          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - directed checks of round-robin, fixed priority, watchdog and reset behaviour
module tb_dram_port_arbiter;
  import dram_if_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dram_req_if  #(.N_PORTS(3)) rq_rr ();
  dram_req_if  #(.N_PORTS(3)) rq_fp ();
  dram_chan_if                dr_rr ();
  dram_chan_if                dr_fp ();

  logic [1:0] gid_rr, gid_fp;
  logic       busy_rr, busy_fp, err_rr, err_fp;

  dram_port_arbiter #(.N_PORTS(3), .PRIO_MODE(PRIO_RR), .TIMEOUT_CYC(8)) dut_rr (
    .clk(clk), .rstn(rstn), .req(rq_rr), .dram(dr_rr),
    .grant_id(gid_rr), .busy(busy_rr), .err_timeout(err_rr)
  );

  dram_port_arbiter #(.N_PORTS(3), .PRIO_MODE(PRIO_FIXED), .TIMEOUT_CYC(0)) dut_fp (
    .clk(clk), .rstn(rstn), .req(rq_fp), .dram(dr_fp),
    .grant_id(gid_fp), .busy(busy_fp), .err_timeout(err_fp)
  );

  int checks;
  int fails;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input bit v, input bit rw, input logic [26:0] a, input logic [31:0] d);
    rq_rr.req_valid[p]         = v;
    rq_rr.req_rw[p]            = rw;
    rq_rr.req_addr[p*27 +: 27] = a;
    rq_rr.req_din[p*32 +: 32]  = d;
  endtask

  task automatic pulse_ready(input logic [31:0] d);
    dr_rr.dout_dram  = d;
    dr_rr.ready_dram = 1'b1;
    @(negedge clk);
    dr_rr.ready_dram = 1'b0;
  endtask

  task automatic wait_rr_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = dr_rr.valid_dram;
    end
  endtask

  task automatic wait_fp_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = |rq_fp.req_ready;
    end
  endtask

  // Fixed-priority DUT: controller answers one cycle after each request.
  initial begin
    dr_fp.ready_dram = 1'b0;
    dr_fp.dout_dram  = 32'h5A5A0000;
    forever begin
      @(negedge clk);
      dr_fp.ready_dram = dr_fp.valid_dram && !dr_fp.ready_dram;
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout got=stuck exp=finish");
    $fatal(1);
  end

  int exp_seq[6] = '{2, 0, 1, 2, 0, 1};
  bit ok;

  initial begin
    checks = 0;
    fails  = 0;
    rstn   = 1'b0;
    rq_rr.req_valid = '0; rq_rr.req_rw = '0; rq_rr.req_addr = '0; rq_rr.req_din = '0;
    rq_fp.req_valid = '0; rq_fp.req_rw = '0; rq_fp.req_addr = '0; rq_fp.req_din = '0;
    dr_rr.ready_dram = 1'b0;
    dr_rr.dout_dram  = '0;
    repeat (3) @(negedge clk);

    check("rst_valid", dr_rr.valid_dram, 0);
    check("rst_busy",  busy_rr, 0);
    check("rst_ready", rq_rr.req_ready, 0);
    check("rst_gid",   gid_rr, 0);
    check("rst_err",   err_rr, 0);
    check("rst_addr",  dr_rr.addr_dram, 0);
    check("rst_fp",    {dr_fp.valid_dram, busy_fp, gid_fp}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // single read on port 0
    set_port(0, 1, 0, 27'h0000123, 32'h0);
    @(negedge clk);
    check("rd_valid", dr_rr.valid_dram, 1);
    check("rd_addr",  dr_rr.addr_dram, 27'h0000123);
    check("rd_rw",    dr_rr.rw_dram, 0);
    check("rd_gid",   gid_rr, 0);
    check("rd_busy",  busy_rr, 1);
    repeat (3) begin
      @(negedge clk);
      check("rd_hold", {dr_rr.valid_dram, dr_rr.addr_dram}, {1'b1, 27'h0000123});
    end
    pulse_ready(32'hDEADBEEF);
    check("rd_ready", rq_rr.req_ready, 3'b001);
    check("rd_dout",  rq_rr.req_dout, 32'hDEADBEEF);
    check("rd_vdrop", dr_rr.valid_dram, 0);
    check("rd_busy1", busy_rr, 1);
    rq_rr.req_valid[0] = 1'b0;
    @(negedge clk);
    check("rd_ready0", rq_rr.req_ready, 0);
    check("rd_busy0",  busy_rr, 0);

    // write on port 1 at the top of the address range
    set_port(1, 1, 1, 27'h7FFFFFF, 32'hA5A5A5A5);
    @(negedge clk);
    check("wr_addr", dr_rr.addr_dram, 27'h7FFFFFF);
    check("wr_din",  dr_rr.din_dram, 32'hA5A5A5A5);
    check("wr_rw",   dr_rr.rw_dram, 1);
    check("wr_gid",  gid_rr, 1);
    repeat (2) @(negedge clk);
    check("wr_hold", {dr_rr.valid_dram, dr_rr.rw_dram, dr_rr.addr_dram, dr_rr.din_dram},
          {1'b1, 1'b1, 27'h7FFFFFF, 32'hA5A5A5A5});
    pulse_ready(32'h11111111);
    check("wr_ready", rq_rr.req_ready, 3'b010);
    rq_rr.req_valid[1] = 1'b0;
    @(negedge clk);

    // round-robin contention; last grant was port 1, so port 2 is next
    for (int p = 0; p < 3; p++) set_port(p, 1, 0, 27'h100 + 27'(p), 32'h0);
    for (int n = 0; n < 6; n++) begin
      wait_rr_valid(ok);
      check("rr_wait", ok, 1);
      check("rr_gid",  gid_rr, exp_seq[n]);
      check("rr_addr", dr_rr.addr_dram, 27'h100 + 27'(exp_seq[n]));
      pulse_ready(32'h100 + 32'(n));
      check("rr_ready", rq_rr.req_ready, 3'b001 << exp_seq[n]);
    end
    rq_rr.req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    // watchdog: no response for 8 cycles in ISSUE
    set_port(0, 1, 0, 27'h42, 32'h0);
    @(negedge clk);
    check("wd_valid", dr_rr.valid_dram, 1);
    repeat (7) @(negedge clk);
    check("wd_err_pre", err_rr, 0);
    @(negedge clk);
    check("wd_err", err_rr, 1);
    check("wd_still_valid", dr_rr.valid_dram, 1);
    repeat (5) @(negedge clk);
    check("wd_wait", {dr_rr.valid_dram, err_rr}, 2'b11);
    pulse_ready(32'hCAFE0001);
    check("wd_ready", rq_rr.req_ready, 3'b001);
    check("wd_dout",  rq_rr.req_dout, 32'hCAFE0001);
    check("wd_sticky", err_rr, 1);
    rq_rr.req_valid[0] = 1'b0;
    @(negedge clk);
    check("wd_idle_busy", busy_rr, 0);
    dr_rr.ready_dram = 1'b1;
    @(negedge clk);
    dr_rr.ready_dram = 1'b0;
    check("spur_ready", rq_rr.req_ready, 0);
    check("spur_state", {busy_rr, dr_rr.valid_dram}, 0);
    @(negedge clk);
    check("spur_ready2", rq_rr.req_ready, 0);
    check("spur_err", err_rr, 1);

    // reset while a request is outstanding; port 0 was last, so port 2 wins
    set_port(2, 1, 0, 27'h77, 32'h0);
    @(negedge clk);
    check("mr_valid", dr_rr.valid_dram, 1);
    check("mr_gid",   gid_rr, 2);
    #2 rstn = 1'b0;
    #1;
    check("mr_async", {dr_rr.valid_dram, busy_rr, rq_rr.req_ready, err_rr}, 0);
    for (int p = 0; p < 3; p++) set_port(p, 1, 0, 27'h200 + 27'(p), 32'h0);
    @(negedge clk);
    check("mr_held", dr_rr.valid_dram, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("mr_first_gid", gid_rr, 0);
    check("mr_first_addr", {dr_rr.valid_dram, dr_rr.addr_dram}, {1'b1, 27'h200});
    pulse_ready(32'h0);
    check("mr_ready", rq_rr.req_ready, 3'b001);
    rq_rr.req_valid = '0;

    // fixed priority: port 0 starves port 2 until it lets go
    rq_fp.req_valid = 3'b101;
    for (int n = 0; n < 3; n++) begin
      wait_fp_ready(ok);
      check("fp_wait",  ok, 1);
      check("fp_ready", rq_fp.req_ready, 3'b001);
      check("fp_gid",   gid_fp, 0);
    end
    rq_fp.req_valid[0] = 1'b0;
    wait_fp_ready(ok);
    check("fp_wait2",  ok, 1);
    check("fp_ready2", rq_fp.req_ready, 3'b100);
    check("fp_gid2",   gid_fp, 2);
    rq_fp.req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
